// File: rtl/stream_reverse_pp.sv
// stream_reverse_pp
//   Ping-pong block reverser. Beats arriving on the input side are packed
//   into one of two banks; a bank closes after N beats or on a beat flagged
//   in_last. Closed banks drain on the output side either reversed or in
//   arrival order, chosen by rev_en sampled on the first beat of each block.
//   While one bank drains, the other fills, so N-beat blocks stream at one
//   beat per cycle.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   rev_en              block mode, sampled on the first accepted beat
//   in_valid/in_ready   input handshake; in_data, in_last with the beat
//   out_valid/out_ready output handshake; out_data, out_last with the beat
//
// Handshake: a beat moves on a side when valid && ready are both high at a
// rising edge. valid never waits on ready, and a presented output beat holds
// its data/last until it is taken. in_ready depends only on registered bank
// flags (and rst), never on out_ready.

module stream_reverse_pp #(
   parameter int DATA_W = 32,
   parameter int N      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rev_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = $clog2(N + 1);

   // Bank storage and per-bank state
   logic [DATA_W-1:0] mem_q   [2][N];
   logic [DATA_W-1:0] mem_d   [2][N];
   logic [1:0]        full_q, full_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  count_q [2];
   logic [CNT_W-1:0]  count_d [2];

   // Write side
   logic              wr_bank_q, wr_bank_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

   // Read side: rd_cnt counts beats already emitted from the current bank
   logic              rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;

   logic              in_fire;
   logic              out_fire;
   logic              wr_close;
   logic              rd_last;
   logic [CNT_W-1:0]  rev_idx;
   logic [IDX_W-1:0]  rd_idx;

   // rst gates in_ready so nothing is accepted during reset cycles
   assign in_ready  = !rst && !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // Close on the last slot or on in_last; both together close only once
   assign wr_close  = in_last || (wr_idx_q == IDX_W'(N - 1));

   assign rd_last   = (CNT_W'(rd_cnt_q) == (count_q[rd_bank_q] - CNT_W'(1)));
   assign rev_idx   = count_q[rd_bank_q] - CNT_W'(1) - CNT_W'(rd_cnt_q);
   assign rd_idx    = mode_q[rd_bank_q] ? rev_idx[IDX_W-1:0] : rd_cnt_q;

   assign out_data  = out_valid ? mem_q[rd_bank_q][rd_idx] : '0;
   assign out_last  = out_valid && rd_last;

   always_comb begin
      mem_d     = mem_q;
      full_d    = full_q;
      mode_d    = mode_q;
      count_d   = count_q;
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;

      // A writable bank is never full and a readable bank always is, so the
      // write and read updates below never touch the same bank.
      if (in_fire) begin
         mem_d[wr_bank_q][wr_idx_q] = in_data;
         if (wr_idx_q == '0) begin
            mode_d[wr_bank_q] = rev_en;
         end
         if (wr_close) begin
            full_d[wr_bank_q]  = 1'b1;
            count_d[wr_bank_q] = CNT_W'(wr_idx_q) + CNT_W'(1);
            wr_bank_d          = !wr_bank_q;
            wr_idx_d           = '0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end

      if (out_fire) begin
         if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= '0;
         mode_q    <= '0;
         count_q   <= '{default: '0};
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= '0;
      end else begin
         full_q    <= full_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         wr_bank_q <= wr_bank_d;
         wr_idx_q  <= wr_idx_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   // Bank contents need no reset: a bank is only read once it is full
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_stream_reverse_pp.sv
module tb_stream_reverse_pp;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int DW2 = 8;
  localparam int N2  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rev_en, in_valid, in_last, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;

  logic           rev_en2, in_valid2, in_last2, out_ready2;
  logic [DW2-1:0] in_data2;
  logic           in_ready2, out_valid2, out_last2;
  logic [DW2-1:0] out_data2;

  stream_reverse_pp #(.DATA_W(DW), .N(N)) u_dut (
    .clk(clk), .rst(rst), .rev_en(rev_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  stream_reverse_pp #(.DATA_W(DW2), .N(N2)) u_dut2 (
    .clk(clk), .rst(rst), .rev_en(rev_en2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Blocks are collected as plain lists; a closed block is expanded into
  // expected {last,data} words in output order.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] cur_q[$];
  logic          cur_mode;
  logic [DW:0]   obs_q[$];
  logic [DW:0]   lit_q[$];
  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!out_valid) check("idle_zero", 64'({out_last, out_data}), 64'd0);
      if (rst) begin
        cur_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_word", 64'({out_last, out_data}), 64'(prev_word));
        end
        if (out_valid && out_ready) begin
          obs_q.push_back({out_last, out_data});
          if (exp_q.size() == 0)
            check("unexpected_beat", 64'({out_last, out_data}), 64'hdead_beef_dead_beef);
          else
            check("out_beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
        if (in_valid && in_ready) begin
          if (cur_q.size() == 0) cur_mode = rev_en;
          cur_q.push_back(in_data);
          if (in_last || cur_q.size() == N) begin
            for (int i = 0; i < cur_q.size(); i++) begin
              int j;
              j = cur_mode ? cur_q.size() - 1 - i : i;
              exp_q.push_back({(i == cur_q.size() - 1), cur_q[j]});
            end
            cur_q.delete();
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
      end
    end
  end

  logic [DW2:0] obs2_q[$];
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid2 && out_ready2) obs2_q.push_back({out_last2, out_data2});
  end

  // ---------------- out_ready driver ----------------
  // 0: always ready, 1: never ready, 2: random
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic r, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    rev_en   = r;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 500) begin
        check("accept_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || out_valid) && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_timeout", 64'(cnt < 400), 64'd1);
  endtask

  task automatic check_obs(input string tag);
    check({tag, "_len"}, 64'(obs_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < obs_q.size(); i++)
      check(tag, 64'(obs_q[i]), 64'(lit_q[i]));
  endtask

  // 4,3,2,1,8,7,6,5,12,11,10,9 with last on 1, 5, 9
  task automatic load_lit_12();
    lit_q.delete();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++)
        lit_q.push_back({(i == 3), DW'(4 * b + 4 - i)});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w, tot;
    int sent;
    logic [DW2-1:0] v2 [3];

    rst = 1'b1;
    rev_en = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rev_en2 = 1'b1; in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_word", 64'({out_last, out_data}), 64'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Test 1: continuous reversed stream, latency, no input stalls
    ready_mode = 0;
    obs_q.delete();
    tot = 0;
    for (int v = 1; v <= 12; v++) begin
      if (v == 4) check("lat_before", 64'(out_valid), 64'd0);
      send_beat(DW'(v), 1'b0, 1'b1, w);
      tot += w;
      if (v == 4) check("lat_after", 64'(out_valid), 64'd1);
    end
    check("t1_no_stall", 64'(tot), 64'd0);
    wait_drain();
    load_lit_12();
    check_obs("t1_order");

    // Test 2: forward then reversed, mid-block rev_en toggles ignored
    obs_q.delete();
    for (int v = 1; v <= 8; v++)
      send_beat(DW'(v), 1'b0, (v == 5 || v == 7), w);
    wait_drain();
    lit_q.delete();
    for (int v = 1; v <= 4; v++) lit_q.push_back({(v == 4), DW'(v)});
    for (int v = 8; v >= 5; v--) lit_q.push_back({(v == 5), DW'(v)});
    check_obs("t2_order");

    // Test 3: early termination and a single-beat block
    obs_q.delete();
    send_beat(DW'(10), 1'b0, 1'b1, w);
    send_beat(DW'(20), 1'b0, 1'b1, w);
    send_beat(DW'(30), 1'b1, 1'b1, w);
    send_beat(DW'(40), 1'b1, 1'b1, w);
    wait_drain();
    lit_q.delete();
    lit_q.push_back({1'b0, DW'(30)});
    lit_q.push_back({1'b0, DW'(20)});
    lit_q.push_back({1'b1, DW'(10)});
    lit_q.push_back({1'b1, DW'(40)});
    check_obs("t3_order");

    // Test 4: output stalled, both banks fill, producer backs off
    ready_mode = 1;
    idle(2);
    obs_q.delete();
    tot = 0;
    for (int v = 1; v <= 8; v++) begin
      send_beat(DW'(v), 1'b0, 1'b1, w);
      tot += w;
      if (v == 7) check("t4_ready_b7", 64'(in_ready), 64'd1);
      if (v == 8) check("t4_ready_b8", 64'(in_ready), 64'd0);
    end
    check("t4_no_stall", 64'(tot), 64'd0);
    in_valid = 1'b1; in_data = DW'(9); in_last = 1'b0; rev_en = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("t4_held_ready", 64'(in_ready), 64'd0);
    check("t4_held_word", 64'({out_last, out_data}), 64'({1'b0, DW'(4)}));
    ready_mode = 0;
    for (int v = 9; v <= 12; v++) send_beat(DW'(v), 1'b0, 1'b1, w);
    wait_drain();
    load_lit_12();
    check_obs("t4_order");

    // Test 4b: random out_ready, same order
    ready_mode = 2;
    obs_q.delete();
    for (int v = 1; v <= 12; v++) send_beat(DW'(v), 1'b0, 1'b1, w);
    wait_drain();
    check_obs("t4b_order");

    // Test 5: reset mid-block and mid-drain
    ready_mode = 0;
    idle(2);
    send_beat(DW'(1), 1'b0, 1'b1, w);
    send_beat(DW'(2), 1'b0, 1'b1, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5a_valid", 64'(out_valid), 64'd0);
    check("t5a_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    idle(4);
    check("t5a_no_stale", 64'(out_valid), 64'd0);
    for (int v = 21; v <= 24; v++) send_beat(DW'(v), 1'b0, 1'b1, w);
    idle(1);
    check("t5b_draining", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5b_valid", 64'(out_valid), 64'd0);
    check("t5b_word", 64'({out_last, out_data}), 64'd0);
    rst = 1'b0;
    idle(4);
    check("t5b_no_stale", 64'(out_valid), 64'd0);
    obs_q.delete();
    for (int v = 5; v <= 8; v++) send_beat(DW'(v), 1'b0, 1'b1, w);
    wait_drain();
    lit_q.delete();
    for (int v = 8; v >= 5; v--) lit_q.push_back({(v == 5), DW'(v)});
    check_obs("t5_order");

    // Random blocks: lengths 1..N, random mode, data, gaps and out_ready
    ready_mode = 2;
    obs_q.delete();
    sent = 0;
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, N);
      for (int k = 0; k < len; k++) begin
        logic l;
        l = (k == len - 1) && (len < N || $urandom_range(0, 1) == 1);
        send_beat(DW'($urandom), l, 1'($urandom_range(0, 1)), w);
        sent++;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    wait_drain();
    check("rand_count", 64'(obs_q.size()), 64'(sent));
    ready_mode = 0;

    // N=2, 8-bit instance
    v2[0] = 8'hAA; v2[1] = 8'hBB; v2[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      int cnt;
      in_valid2 = 1'b1;
      in_data2  = v2[i];
      in_last2  = (i == 2);
      cnt = 0;
      forever begin
        @(negedge clk);
        if (in_ready2 || cnt > 50) break;
        cnt++;
      end
      check("n2_accept", 64'(in_ready2), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    idle(8);
    check("n2_len", 64'(obs2_q.size()), 64'd3);
    if (obs2_q.size() == 3) begin
      check("n2_beat0", 64'(obs2_q[0]), 64'({1'b0, 8'hBB}));
      check("n2_beat1", 64'(obs2_q[1]), 64'({1'b1, 8'hAA}));
      check("n2_beat2", 64'(obs2_q[2]), 64'({1'b1, 8'hFF}));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_reverse_pp.md
Name: stream_reverse_pp

Overview:
Parametrised, full-throughput successor to the team's single-buffer N-beat stream reverser. Ping-pong buffered: one bank fills while the other drains, so there are no dead cycles between blocks. Both sides use valid/ready handshakes. Supports early block termination via in_last and a per-block reverse/forward mode. Sits between a streaming producer and consumer in the datapath.

Parameters:
DATA_W, 32, data beat width in bits
N, 4, maximum beats per block; legal range N >= 2

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rev_en  input  1  1 = emit block reversed, 0 = emit in arrival order; sampled on the first accepted beat of each block
in_valid  input  1  producer beat valid
in_ready  output  1  block can accept a beat
in_data  input  DATA_W  input beat
in_last  input  1  beat closes the current block early
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts beat
out_data  output  DATA_W  output beat
out_last  output  1  final beat of an output block

Behaviour:
- Transfer occurs on a side when valid && ready are both high at a rising edge.
- Storage: two banks (bank0, bank1), each N x DATA_W. Per bank: full flag, count (width $clog2(N+1)), latched mode bit.
- Write side: wr_bank pointer starts at bank0. in_ready = !full[wr_bank], a registered-flag function only, with no combinational path from out_ready.
  - Accepted beat k (0-based) is stored at index k.
  - First beat of a block latches rev_en into the bank's mode bit.
  - Block closes on acceptance of beat N-1, or of any beat with in_last=1. At close: full[wr_bank]<=1, count<=k+1, wr_bank toggles, write index clears.
  - in_last on beat N-1 produces a single close, never an empty extra block.
- Read side: rd_bank pointer starts at bank0. out_valid = full[rd_bank].
  - Reverse mode: index order count-1 down to 0. Forward mode: 0 up to count-1.
  - out_last=1 on the final beat of the block.
  - On final beat transfer: full[rd_bank]<=0, rd_bank toggles, read index reloads.
- out_data, out_last and out_valid stay stable while out_valid && !out_ready. out_data=0 and out_last=0 whenever out_valid=0.
- Latency: the first output beat of a block is valid in the cycle after the closing beat's acceptance edge (1 cycle).
- Throughput: with out_ready held high and N-beat blocks, the input accepts one beat every cycle indefinitely.
  - A bank freed at edge t is writable from cycle t+1.
  - The same bank is never written and read in one cycle.
- Both banks full: in_ready=0 and the producer stalls. in_valid is ignored while in_ready=0.
- Both banks empty: out_valid=0.
- Single-beat block (in_last on beat 0): count=1; the output is one beat with out_last=1 in either mode.
- rev_en changes mid-block have no effect until the next block's first beat.
- Reset, including mid-block: in_ready=0 during reset cycles and 1 in the first cycle after reset deasserts. out_valid=0, out_data=0, out_last=0. Both full flags clear, both pointers go to bank0, indices clear. Buffered data is discarded and never emitted.
- The out_valid to out_ready path is registered only. No combinational in-to-out paths.

Test Plan:
- N=4, rev_en=1, out_ready=1, continuous beats 1..12 -> output 4,3,2,1,8,7,6,5,12,11,10,9. in_ready never drops after reset. First out_valid 1 cycle after beat 4 is accepted. out_last on 1, 5 and 9.
- N=4, rev_en=0 for beats 1-4, rev_en=1 on beat 5 -> output 1,2,3,4,8,7,6,5. Toggling rev_en during beats 6-7 has no effect.
- N=4, rev_en=1, beats 10,20,30 with in_last on 30, then beat 40 with in_last -> output 30,20,10 (last on 10), then 40 (last on 40).
- N=4, out_ready=0, stream 1..12 -> in_ready falls after beat 8 is accepted. Raising out_ready gives 4,3,2,1,8,7,6,5, then 12..9, with data held stable during stalls. Random out_ready must give the same order.
- Assert rst after beats 1,2 and again mid-drain of a full block -> out_valid=0 and out_data=0 next cycle, no stale beats afterwards. Beats 5..8 after reset emit 8,7,6,5.
- N=2, DATA_W=8, beats 0xAA,0xBB,0xFF with in_last on 0xFF -> output 0xBB,0xAA,0xFF. out_last on 0xAA and 0xFF.
